// File: rtl/seg_pkg.sv
// seg_pkg: shared digit-code constants and types for the seven-segment scan path
package seg_pkg;
    localparam int CODE_W = 5;
    localparam logic [CODE_W-1:0] CODE_BLANK = 5'd31;
    localparam logic [CODE_W-1:0] CODE_EQ = 5'd16;
    typedef logic [6:0] seg_t;
    typedef enum logic {S_GUARD, S_DRIVE} scan_state_t;
endpackage

// File: rtl/seg_scan_ctrl_dec.sv
// seg_scan_ctrl_dec: digit code to a..g segment pattern (hex, '=', others dark)
module seg_scan_ctrl_dec
    import seg_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output seg_t              seg
);
    always_comb begin
        case (code)
            5'd0:    seg = 7'b1111110;
            5'd1:    seg = 7'b0110000;
            5'd2:    seg = 7'b1101101;
            5'd3:    seg = 7'b1111001;
            5'd4:    seg = 7'b0110011;
            5'd5:    seg = 7'b1011011;
            5'd6:    seg = 7'b1011111;
            5'd7:    seg = 7'b1110000;
            5'd8:    seg = 7'b1111111;
            5'd9:    seg = 7'b1111011;
            5'd10:   seg = 7'b1110111;
            5'd11:   seg = 7'b0011111;
            5'd12:   seg = 7'b1001110;
            5'd13:   seg = 7'b0111101;
            5'd14:   seg = 7'b1001111;
            5'd15:   seg = 7'b1000111;
            CODE_EQ: seg = 7'b0001001;
            default: seg = 7'b0000000;
        endcase
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: double-buffered multiplexed scan of an N-digit common-anode display
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DIV        = 50000,
    parameter int GUARD      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [CODE_W*NUM_DIGITS-1:0] load_data,
    input  logic                         blank_lz,
    output logic [NUM_DIGITS-1:0]        an,
    output seg_t                         seg,
    output logic                         frame_done
);
    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    scan_state_t state, state_n;
    logic [NUM_DIGITS-1:0][CODE_W-1:0] disp, pend;
    logic pend_v, slot_end, boundary, drive;
    logic [CODE_W-1:0] code;
    logic [NUM_DIGITS-1:0] lz, an_d;
    seg_t dec_seg, seg_d;

    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [NUM_DIGITS-1:0][CODE_W-1:0] c, input logic en);
        logic z;
        z = en;
        lz_mask = '0;
        for (int i = NUM_DIGITS-1; i > 0; i--) begin
            z = z & (c[i] == '0);
            lz_mask[i] = z;
        end
    endfunction

    assign code       = disp[idx];
    assign lz         = lz_mask(disp, blank_lz);
    assign slot_end   = cnt == CW'(DIV-1);
    assign boundary   = slot_end && idx == IW'(NUM_DIGITS-1);
    assign load_ready = ~pend_v;

    seg_scan_ctrl_dec u_dec (.code(code), .seg(dec_seg));

    // CODE_BLANK keeps the anode off so an empty display draws no current
    always_comb begin
        state_n = (state == S_GUARD && cnt == CW'(GUARD-1)) ? S_DRIVE :
                  (state == S_DRIVE && slot_end) ? S_GUARD : state;
        drive   = state == S_DRIVE && !lz[idx] && code != CODE_BLANK;
        an_d    = drive ? ~(NUM_DIGITS'(1) << idx) : '1;
        seg_d   = drive ? dec_seg : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_GUARD;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            pend_v     <= 1'b0;
            pend       <= '0;
            disp       <= {NUM_DIGITS{CODE_BLANK}};
            an         <= '1;
            seg        <= '0;
            frame_done <= 1'b0;
        end else begin
            cnt        <= slot_end ? '0 : cnt + 1'b1;
            idx        <= !slot_end ? idx : (idx == IW'(NUM_DIGITS-1)) ? '0 : idx + 1'b1;
            an         <= an_d;
            seg        <= seg_d;
            frame_done <= boundary;
            if (boundary && pend_v) begin
                disp   <= pend;
                pend_v <= 1'b0;
            end else if (load_valid && load_ready) begin
                pend   <= load_data;
                pend_v <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed and random checks of seg_scan_ctrl against a cycle-count model
module tb_seg_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic        load_ready;
    logic [19:0] load_data;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_done;

    localparam logic [6:0] DEC [17] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F,
                                        7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47, 7'h09};

    int t, passes, total, acc_t, first_fd;
    logic [4:0] md [4];
    logic [4:0] mp [4];
    bit mpv, last_acc;

    seg_scan_ctrl #(.NUM_DIGITS(4), .DIV(8), .GUARD(2)) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .blank_lz(blank_lz), .an(an), .seg(seg), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic reset_model();
        t = 0;
        mpv = 0;
        for (int i = 0; i < 4; i++) md[i] = 5'd31;
    endtask

    // Expected {frame_done, an, seg} registered from cycle t
    function automatic logic [11:0] model_out();
        int cn, ix;
        bit bl, z, drv;
        logic [3:0] a;
        logic [6:0] s;
        cn = t % 8;
        ix = (t / 8) % 4;
        bl = md[ix] == 5'd31;
        if (ix != 0 && blank_lz) begin
            z = 1;
            for (int i = ix; i < 4; i++) if (md[i] != 0) z = 0;
            bl = bl | z;
        end
        drv = cn >= 2 && !bl;
        a = drv ? ~(4'b1 << ix) : 4'hF;
        s = (drv && md[ix] < 17) ? DEC[int'(md[ix])] : 7'h00;
        return {(t % 32) == 31, a, s};
    endfunction

    task automatic tick();
        logic [11:0] e;
        bit acc;
        chk("load_ready", {31'd0, load_ready}, {31'd0, !mpv});
        e = model_out();
        acc = load_valid && !mpv;
        @(posedge clk);
        #1;
        chk("frame_done", {31'd0, frame_done}, {31'd0, e[11]});
        chk("an", {28'd0, an}, {28'd0, e[10:7]});
        chk("seg", {25'd0, seg}, {25'd0, e[6:0]});
        if ((t % 32) == 31 && mpv) begin
            for (int i = 0; i < 4; i++) md[i] = mp[i];
            mpv = 0;
        end else if (acc) begin
            for (int i = 0; i < 4; i++) mp[i] = load_data[5*i +: 5];
            mpv = 1;
            acc_t = t;
        end
        last_acc = acc;
        t++;
    endtask

    task automatic run_to(input int pos);
        for (int k = 0; k < 64; k++) begin
            tick();
            if (((t - 1) % 32) == pos) return;
        end
        chk("run_to_timeout", 0, 1);
    endtask

    task automatic load(input logic [19:0] d);
        load_valid = 1;
        load_data = d;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (last_acc) break;
        end
        load_valid = 0;
        load_data = 20'($urandom);
        chk("load_accept", {31'd0, last_acc}, 1);
    endtask

    function automatic logic [19:0] rnd_frame();
        logic [19:0] d;
        for (int i = 0; i < 4; i++) d[5*i +: 5] = ($urandom % 2) ? 5'd0 : 5'($urandom % 32);
        return d;
    endfunction

    initial begin
        passes = 0;
        total = 0;
        rst_n = 0;
        load_valid = 0;
        load_data = '0;
        blank_lz = 0;
        reset_model();
        #12;
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_seg", {25'd0, seg}, 0);
        chk("rst_ready", {31'd0, load_ready}, 1);
        chk("rst_fd", {31'd0, frame_done}, 0);
        @(posedge clk);
        #1;
        rst_n = 1;

        repeat (3) tick();
        load({5'd3, 5'd2, 5'd1, 5'd0});
        chk("load_cycle", acc_t, 3);
        run_to(12);
        chk("first_frame_blank", {28'd0, an}, 32'hF);
        run_to(1);
        chk("guard_an", {28'd0, an}, 32'hF);
        chk("guard_seg", {25'd0, seg}, 0);
        run_to(2);
        chk("d0_an", {28'd0, an}, 32'hE);
        chk("d0_seg", {25'd0, seg}, 32'h7E);
        run_to(26);
        chk("d3_an", {28'd0, an}, 32'h7);
        chk("d3_seg", {25'd0, seg}, 32'h79);

        load(rnd_frame());
        load(rnd_frame());
        chk("bp_accept_pos", acc_t % 32, 0);

        blank_lz = 1;
        load({5'd0, 5'd0, 5'd4, 5'd0});
        run_to(31);
        run_to(2);
        chk("lz_d0_an", {28'd0, an}, 32'hE);
        chk("lz_d0_seg", {25'd0, seg}, 32'h7E);
        run_to(10);
        chk("lz_d1_an", {28'd0, an}, 32'hD);
        chk("lz_d1_seg", {25'd0, seg}, 32'h33);
        run_to(18);
        chk("lz_d2_an", {28'd0, an}, 32'hF);
        run_to(26);
        chk("lz_d3_an", {28'd0, an}, 32'hF);
        chk("lz_d3_seg", {25'd0, seg}, 0);
        blank_lz = 0;
        run_to(26);
        chk("nolz_d3_seg", {25'd0, seg}, 32'h7E);

        load({5'd0, 5'd0, 5'd16, 5'd8});
        run_to(10);
        chk("eq_seg", {25'd0, seg}, 32'h09);
        load({5'd0, 5'd0, 5'd20, 5'd8});
        run_to(31);
        run_to(10);
        chk("c20_an", {28'd0, an}, 32'hD);
        chk("c20_seg", {25'd0, seg}, 0);

        for (int k = 0; k < 320; k++) begin
            load_valid = ($urandom % 4) == 0;
            load_data = rnd_frame();
            blank_lz = 1'($urandom % 2);
            tick();
        end
        load_valid = 0;
        blank_lz = 0;

        run_to(1);
        load({5'd9, 5'd8, 5'd7, 5'd6});
        run_to(12);
        chk("pend_held", {31'd0, load_ready}, 0);
        rst_n = 0;
        #1;
        chk("arst_an", {28'd0, an}, 32'hF);
        chk("arst_seg", {25'd0, seg}, 0);
        chk("arst_ready", {31'd0, load_ready}, 1);
        chk("arst_fd", {31'd0, frame_done}, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        reset_model();
        first_fd = -1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (frame_done && first_fd < 0) first_fd = k + 1;
        end
        chk("fd_after_reset", first_fd, 32);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
